instr_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32I core. Owns the PC register, instruction register and load-data register, and drives the combinational decode/execute unit with them. Shares one memory bus between instruction fetch and data load/store, and gates register-file writes and PC updates to one retire point per instruction. Sits between the single-port memory bus and the combinational control, register file and ALU.

---
 rtl/instr_sequencer_if.sv | 11 +
 rtl/instr_sequencer.sv | 110 +++++++++++
 tb/tb_instr_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: single-port memory bus shared by fetch and load/store
interface instr_sequencer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle RV32I fetch/exec/load/store sequencer; SEQ_TRAP_EN adds a trap HALT state
module instr_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_sequencer_if.master         bus,
  output logic [31:0]               pc_out,
  input  logic [31:0]               pc_next_in,
  output logic [31:0]               instr_out,
  input  logic                      reg_wr_en_in,
  output logic                      reg_wr_commit_out,
  input  logic [31:0]               dmem_rd_addr_in,
  input  logic [31:0]               dmem_wr_addr_in,
  input  logic [31:0]               dmem_wr_data_in,
  output logic [31:0]               dmem_rd_data_out,
  output logic [31:0]               instret_out,
  output logic                      halt_out
);
  typedef enum logic [2:0] {
    FETCH, EXEC, LOAD, STORE, WB
`ifdef SEQ_TRAP_EN
    , HALT
`endif
  } state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ld_q, ld_d, instret_q, instret_d;
  logic        retire, commit, legal;
  logic [6:0]  opc;
  assign opc = ir_q[6:0];
  assign legal = opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  // Registered architectural state; reset wins over any in-flight transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      ld_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ld_q      <= ld_d;
      instret_q <= instret_d;
    end
  end
  // Next state, with a single retire point that updates PC and instret together
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ld_d      = ld_q;
    instret_d = instret_q;
    retire    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      FETCH: if (bus.ack) begin
        ir_d    = bus.rdata;
        state_d = EXEC;
      end
      EXEC: if (opc == 7'b0000011) state_d = LOAD;
        else if (opc == 7'b0100011) state_d = STORE;
        else begin
          retire = 1'b1;
          commit = reg_wr_en_in && legal;
        end
      LOAD: if (bus.ack) begin
        ld_d    = bus.rdata;
        state_d = WB;
      end
      WB: begin
        retire = 1'b1;
        commit = 1'b1;
      end
      STORE: retire = bus.ack;
      default: ;
    endcase
    if (retire) begin
`ifdef SEQ_TRAP_EN
      if (!legal || pc_next_in[1:0] != 2'b00) begin
        state_d = HALT;
        commit  = 1'b0;
      end else
`endif
      begin
        pc_d      = pc_next_in;
        instret_d = instret_q + 32'd1;
        state_d   = FETCH;
      end
    end
  end
  assign bus.req  = !rst && (state_q == FETCH || state_q == LOAD || state_q == STORE);
  assign bus.we   = state_q == STORE;
  assign bus.addr = state_q == FETCH ? pc_q : state_q == LOAD ? dmem_rd_addr_in :
                    state_q == STORE ? dmem_wr_addr_in : 32'd0;
  assign bus.wdata = state_q == STORE ? dmem_wr_data_in : 32'd0;
  assign reg_wr_commit_out = commit && !rst;
  assign pc_out            = rst ? RESET_PC : pc_q;
  assign instr_out         = rst ? NOP_INSTR : ir_q;
  assign dmem_rd_data_out  = rst ? 32'd0 : ld_q;
  assign instret_out       = rst ? 32'd0 : instret_q;
`ifdef SEQ_TRAP_EN
  assign halt_out = !rst && state_q == HALT;
`else
  assign halt_out = 1'b0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out, pc_next_in, instr_out, dmem_rd_addr_in, dmem_wr_addr_in;
  logic [31:0] dmem_wr_data_in, dmem_rd_data_out, instret_out;
  logic        reg_wr_en_in, reg_wr_commit_out, halt_out;
  int          n_cmp = 0;
  int          n_err = 0;
  instr_sequencer_if bus();
  instr_sequencer #(.RESET_PC(32'h100), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc_out(pc_out), .pc_next_in(pc_next_in),
    .instr_out(instr_out), .reg_wr_en_in(reg_wr_en_in), .reg_wr_commit_out(reg_wr_commit_out),
    .dmem_rd_addr_in(dmem_rd_addr_in), .dmem_wr_addr_in(dmem_wr_addr_in),
    .dmem_wr_data_in(dmem_wr_data_in), .dmem_rd_data_out(dmem_rd_data_out),
    .instret_out(instret_out), .halt_out(halt_out)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.ack = 1'b0; bus.rdata = '0; pc_next_in = '0; reg_wr_en_in = 1'b0;
    dmem_rd_addr_in = '0; dmem_wr_addr_in = '0; dmem_wr_data_in = '0;
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL rst_pc got %h want %h", pc_out, 32'h100); end
    n_cmp++; if (instr_out !== 32'h13) begin n_err++; $display("FAIL rst_ir got %h want %h", instr_out, 32'h13); end
    n_cmp++; if (instret_out !== 32'd0) begin n_err++; $display("FAIL rst_instret got %h want 0", instret_out); end
    n_cmp++; if (dmem_rd_data_out !== 32'd0) begin n_err++; $display("FAIL rst_ld got %h want 0", dmem_rd_data_out); end
    n_cmp++; if ({bus.req, reg_wr_commit_out, halt_out} !== 3'b000) begin n_err++; $display("FAIL rst_req_commit_halt got %b want 000", {bus.req, reg_wr_commit_out, halt_out}); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus.req, bus.we, bus.addr} !== {2'b10, 32'h100}) begin n_err++; $display("FAIL first_fetch got %b%b %h want 10 100", bus.req, bus.we, bus.addr); end
  endtask
  task automatic test_alu();
    bus.ack = 1'b1; bus.rdata = 32'h0050_0093; reg_wr_en_in = 1'b1; pc_next_in = 32'h104;
    tick();
    bus.ack = 1'b0;
    #1;
    n_cmp++; if (instr_out !== 32'h0050_0093) begin n_err++; $display("FAIL alu_ir got %h want 00500093", instr_out); end
    n_cmp++; if ({bus.req, reg_wr_commit_out} !== 2'b01) begin n_err++; $display("FAIL alu_exec got req=%b commit=%b want 0 1", bus.req, reg_wr_commit_out); end
    tick();
    n_cmp++; if ({pc_out, instret_out} !== {32'h104, 32'd1}) begin n_err++; $display("FAIL alu_retire got pc=%h ir=%0d want 104 1", pc_out, instret_out); end
    n_cmp++; if ({bus.req, bus.addr, reg_wr_commit_out} !== {1'b1, 32'h104, 1'b0}) begin n_err++; $display("FAIL alu_next got req=%b addr=%h commit=%b want 1 104 0", bus.req, bus.addr, reg_wr_commit_out); end
  endtask
  task automatic test_load();
    bus.ack = 1'b1; bus.rdata = 32'h0080_2103;
    tick();
    bus.ack = 1'b0; dmem_rd_addr_in = 32'h8; reg_wr_en_in = 1'b1; pc_next_in = 32'h108;
    #1;
    n_cmp++; if ({bus.req, reg_wr_commit_out} !== 2'b00) begin n_err++; $display("FAIL ld_exec got req=%b commit=%b want 0 0", bus.req, reg_wr_commit_out); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({bus.req, bus.we, bus.addr, reg_wr_commit_out} !== {2'b10, 32'h8, 1'b0}) begin n_err++; $display("FAIL ld_wait%0d got req=%b we=%b addr=%h commit=%b", i, bus.req, bus.we, bus.addr, reg_wr_commit_out); end
      if (i == 3) begin bus.ack = 1'b1; bus.rdata = 32'hCAFE_F00D; end
      tick();
    end
    bus.ack = 1'b0; bus.rdata = '0;
    #1;
    n_cmp++; if ({dmem_rd_data_out, reg_wr_commit_out, bus.req} !== {32'hCAFE_F00D, 2'b10}) begin n_err++; $display("FAIL ld_wb got data=%h commit=%b req=%b want cafef00d 1 0", dmem_rd_data_out, reg_wr_commit_out, bus.req); end
    tick();
    n_cmp++; if ({pc_out, instret_out, reg_wr_commit_out, bus.req, bus.addr} !== {32'h108, 32'd2, 2'b01, 32'h108}) begin n_err++; $display("FAIL ld_retire got pc=%h n=%0d commit=%b req=%b addr=%h", pc_out, instret_out, reg_wr_commit_out, bus.req, bus.addr); end
  endtask
  task automatic test_store();
    bus.ack = 1'b1; bus.rdata = 32'h0230_2023;
    tick();
    bus.ack = 1'b0; reg_wr_en_in = 1'b1; dmem_wr_addr_in = 32'h20; dmem_wr_data_in = 32'hDEAD_BEEF; pc_next_in = 32'h10C;
    #1;
    n_cmp++; if ({bus.req, reg_wr_commit_out} !== 2'b00) begin n_err++; $display("FAIL st_exec got req=%b commit=%b want 0 0", bus.req, reg_wr_commit_out); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({bus.req, bus.we, bus.addr, bus.wdata, reg_wr_commit_out} !== {2'b11, 32'h20, 32'hDEAD_BEEF, 1'b0}) begin n_err++; $display("FAIL st_wait%0d got req=%b we=%b addr=%h wdata=%h commit=%b", i, bus.req, bus.we, bus.addr, bus.wdata, reg_wr_commit_out); end
      if (i == 2) bus.ack = 1'b1;
      tick();
    end
    bus.ack = 1'b0;
    #1;
    n_cmp++; if ({bus.req, bus.we, bus.addr, bus.wdata, reg_wr_commit_out} !== {2'b10, 32'h10C, 32'h0, 1'b0}) begin n_err++; $display("FAIL st_b2b_fetch got req=%b we=%b addr=%h wdata=%h commit=%b", bus.req, bus.we, bus.addr, bus.wdata, reg_wr_commit_out); end
    n_cmp++; if ({pc_out, instret_out} !== {32'h10C, 32'd3}) begin n_err++; $display("FAIL st_retire got pc=%h n=%0d want 10c 3", pc_out, instret_out); end
  endtask
  task automatic test_branch();
    bus.ack = 1'b1; bus.rdata = 32'h0000_0063;
    tick();
    bus.ack = 1'b0; reg_wr_en_in = 1'b0; pc_next_in = 32'h80;
    #1;
    n_cmp++; if (reg_wr_commit_out !== 1'b0) begin n_err++; $display("FAIL br_commit got %b want 0", reg_wr_commit_out); end
    tick();
    n_cmp++; if ({pc_out, bus.req, bus.addr, instret_out} !== {32'h80, 1'b1, 32'h80, 32'd4}) begin n_err++; $display("FAIL br_target got pc=%h req=%b addr=%h n=%0d", pc_out, bus.req, bus.addr, instret_out); end
  endtask
`ifdef SEQ_TRAP_EN
  task automatic test_trap();
    bus.ack = 1'b1; bus.rdata = 32'h0000_0000;
    tick();
    bus.ack = 1'b0; reg_wr_en_in = 1'b1; pc_next_in = 32'h84;
    #1;
    n_cmp++; if (reg_wr_commit_out !== 1'b0) begin n_err++; $display("FAIL trap_commit got %b want 0", reg_wr_commit_out); end
    tick();
    n_cmp++; if (halt_out !== 1'b1) begin n_err++; $display("FAIL trap_halt got %b want 1", halt_out); end
    for (int i = 0; i < 20; i++) begin
      bus.ack = 1'b1;
      n_cmp++; if ({bus.req, pc_out, instret_out} !== {1'b0, 32'h80, 32'd4}) begin n_err++; $display("FAIL trap_hold%0d got req=%b pc=%h n=%0d", i, bus.req, pc_out, instret_out); end
      tick();
    end
    bus.ack = 1'b0;
  endtask
`else
  task automatic test_illegal();
    bus.ack = 1'b1; bus.rdata = 32'h0000_0000;
    tick();
    bus.ack = 1'b0; reg_wr_en_in = 1'b1; pc_next_in = 32'h86;
    #1;
    n_cmp++; if ({reg_wr_commit_out, halt_out} !== 2'b00) begin n_err++; $display("FAIL ill_commit got commit=%b halt=%b want 0 0", reg_wr_commit_out, halt_out); end
    tick();
    n_cmp++; if ({pc_out, instret_out, bus.addr} !== {32'h86, 32'd5, 32'h86}) begin n_err++; $display("FAIL ill_nop got pc=%h n=%0d addr=%h want 86 5 86", pc_out, instret_out, bus.addr); end
  endtask
`endif
  task automatic test_reset_mid_load();
    bus.ack = 1'b1; bus.rdata = 32'h0080_2103;
    tick();
    bus.ack = 1'b0; dmem_rd_addr_in = 32'h8; reg_wr_en_in = 1'b1; pc_next_in = 32'h200;
    tick(); tick();
    n_cmp++; if ({bus.req, bus.addr} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL rml_inload got req=%b addr=%h want 1 8", bus.req, bus.addr); end
    rst = 1'b1; bus.ack = 1'b1;
    #1;
    n_cmp++; if ({bus.req, reg_wr_commit_out, pc_out, instret_out} !== {2'b00, 32'h100, 32'd0}) begin n_err++; $display("FAIL rml_during got req=%b commit=%b pc=%h n=%0d", bus.req, reg_wr_commit_out, pc_out, instret_out); end
    tick();
    rst = 1'b0; bus.ack = 1'b0;
    #1;
    n_cmp++; if ({bus.req, bus.we, bus.addr, reg_wr_commit_out, instret_out} !== {2'b10, 32'h100, 1'b0, 32'd0}) begin n_err++; $display("FAIL rml_after got req=%b we=%b addr=%h commit=%b n=%0d", bus.req, bus.we, bus.addr, reg_wr_commit_out, instret_out); end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
`ifdef SEQ_TRAP_EN
    test_trap();
`else
    test_illegal();
`endif
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
